// File: rtl/mod_counter_chain.sv
// rtl/mod_counter_chain.sv - cascaded modulo-N up/down digit counter with sticky wrap flag
// Optional MOD_COUNTER_CHAIN_MATCH_EN adds match_val input and registered match output.
module mod_counter_chain #(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10,
    parameter int DIGIT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        up,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    input  logic                        clr_ovf,
`ifdef MOD_COUNTER_CHAIN_MATCH_EN
    input  logic [DIGITS*DIGIT_W-1:0]   match_val,
`endif
    output logic [DIGITS*DIGIT_W-1:0]   count,
    output logic                        carry_out,
    output logic                        ovf
`ifdef MOD_COUNTER_CHAIN_MATCH_EN
    ,
    output logic                        match
`endif
);

    localparam logic [DIGIT_W-1:0] TOP     = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W:0]   MOD_EXT = (DIGIT_W + 1)'(MODULUS);

    logic [DIGITS-1:0]         term;
    logic [DIGITS-1:0]         step;
    logic [DIGITS*DIGIT_W-1:0] count_next;

    // step ripples up the chain only through digits sitting at their terminal value
    assign step[0] = en & ~load;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            logic [DIGIT_W-1:0] d;
            logic [DIGIT_W-1:0] ld;
            logic [DIGIT_W-1:0] ld_sat;
            logic [DIGIT_W-1:0] stepped;

            assign d       = count[k*DIGIT_W +: DIGIT_W];
            assign ld      = load_val[k*DIGIT_W +: DIGIT_W];
            assign term[k] = up ? (d == TOP) : (d == '0);
            assign ld_sat  = ({1'b0, ld} >= MOD_EXT) ? TOP : ld;
            assign stepped = up ? (term[k] ? '0 : d + 1'b1)
                                : (term[k] ? TOP : d - 1'b1);

            if (k > 0) begin : g_ripple
                assign step[k] = step[k-1] & term[k-1];
            end

            assign count_next[k*DIGIT_W +: DIGIT_W] =
                load ? ld_sat : (step[k] ? stepped : d);
        end
    endgenerate

    assign carry_out = step[DIGITS-1] & term[DIGITS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            // a wrap in the same cycle as clr_ovf keeps the flag set
            if (carry_out)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

`ifdef MOD_COUNTER_CHAIN_MATCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            match <= 1'b0;
        else
            match <= (count == match_val);
    end
`endif

endmodule
